// File: rtl/seg_anim_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seg_anim_scheduler
// Description : Sequences six seven-segment animations (anim 0 = digit count,
//               anims 1-5 = patterns). A 24-bit prescaler produces frame ticks
//               in RUN. Each tick (or a step pulse in PAUSE) advances
//               frame_idx and, on a wrap, anim_sel. A full sequence is 43
//               frames.
// Ports       : clk          - rising-edge clock
//               reset        - synchronous active-high reset
//               start        - pulse, IDLE -> RUN
//               stop         - pulse, any state -> IDLE (highest priority)
//               pause        - level, RUN <-> PAUSE
//               step         - pulse, single frame advance while in PAUSE
//               lock         - level, hold the current anim (frames repeat)
//               div[7:0]     - frame period select (0 selects MAX_COUNT)
//               anim_sel[2:0]    - selected animation
//               frame_idx[3:0]   - frame / digit index for the decoder
//               frame_strobe     - one-cycle pulse on each frame_idx update
//               busy             - high in RUN or PAUSE
//               seq_done         - one-cycle pulse on the anim 5 wrap
//               prescale_lo[7:0] - prescaler bits [7:0] (debug)
// Config      : SEG_ANIM_LOOP_EN - when defined, the anim 5 wrap returns to
//               anim 0 and the block stays in RUN. When undefined, the block
//               returns to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_anim_scheduler #(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
  parameter int unsigned NUM_ANIM  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       step,
  input  logic       lock,
  input  logic [7:0] div,
  output logic [2:0] anim_sel,
  output logic [3:0] frame_idx,
  output logic       frame_strobe,
  output logic       busy,
  output logic       seq_done,
  output logic [7:0] prescale_lo
);

`ifdef SEG_ANIM_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam logic [2:0] LAST_ANIM = 3'(NUM_ANIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t      state_q;
  logic [23:0] cnt_q;
  logic [2:0]  anim_q;
  logic [3:0]  frame_q;
  logic        strobe_q;
  logic        busy_q;
  logic        done_q;

  logic [23:0] compare_d;
  logic        tick_d;
  logic        adv_d;
  logic [3:0]  last_frame_d;
  logic [3:0]  frame_d;
  logic [2:0]  anim_d;
  logic        seq_wrap_d;

  assign compare_d = (div == 8'd0) ? MAX_COUNT : {6'b0, div, 10'b0};

  // Using >= rather than == means that a div change which leaves the counter
  // above the new compare value ticks at once. The counter never has to run
  // through a full 24-bit wrap.
  assign tick_d = (state_q == ST_RUN) && (cnt_q >= compare_d);
  assign adv_d  = tick_d || ((state_q == ST_PAUSE) && step);

  always_comb begin
    last_frame_d = 4'd5;
    case (anim_q)
      3'd0:                last_frame_d = 4'd9;
      3'd1, 3'd2, 3'd3:    last_frame_d = 4'd6;
      default:             last_frame_d = 4'd5;
    endcase
  end

  // Next frame/anim pair. anim only moves together with the frame wrap to 0,
  // so the decoder never sees an index beyond the anim's last frame.
  always_comb begin
    frame_d    = frame_q;
    anim_d     = anim_q;
    seq_wrap_d = 1'b0;
    if (frame_q < last_frame_d) begin
      frame_d = frame_q + 4'd1;
    end else begin
      frame_d = 4'd0;
      if (!lock) begin
        if (anim_q >= LAST_ANIM) begin
          anim_d     = 3'd0;
          seq_wrap_d = 1'b1;
        end else begin
          anim_d = anim_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 24'd0;
      anim_q   <= 3'd0;
      frame_q  <= 4'd0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      if (stop) begin
        state_q <= ST_IDLE;
        cnt_q   <= 24'd0;
        anim_q  <= 3'd0;
        frame_q <= 4'd0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            cnt_q   <= 24'd0;
            anim_q  <= 3'd0;
            frame_q <= 4'd0;
            if (start) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else begin
              busy_q  <= 1'b0;
            end
          end
          ST_RUN, ST_PAUSE: begin
            busy_q <= 1'b1;
            if (state_q == ST_RUN) begin
              cnt_q <= tick_d ? 24'd0 : cnt_q + 24'd1;
              if (pause) state_q <= ST_PAUSE;
            end else begin
              if (!pause) state_q <= ST_RUN;
            end
            if (adv_d) begin
              frame_q  <= frame_d;
              anim_q   <= anim_d;
              strobe_q <= 1'b1;
              done_q   <= seq_wrap_d;
              // End of a non-looping sequence: these assignments override
              // the RUN/PAUSE transitions above.
              if (seq_wrap_d && !LOOP_EN) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= 24'd0;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= 24'd0;
            anim_q  <= 3'd0;
            frame_q <= 4'd0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign anim_sel     = anim_q;
  assign frame_idx    = frame_q;
  assign frame_strobe = strobe_q;
  assign busy         = busy_q;
  assign seq_done     = done_q;
  assign prescale_lo  = cnt_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_seg_anim_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_anim_scheduler
// Description : Directed self-checking bench for seg_anim_scheduler
//               (MAX_COUNT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_anim_scheduler;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       pause;
  logic       step;
  logic       lock;
  logic [7:0] div;
  logic [2:0] anim_sel;
  logic [3:0] frame_idx;
  logic       frame_strobe;
  logic       busy;
  logic       seq_done;
  logic [7:0] prescale_lo;

  int checks   = 0;
  int failures = 0;

  seg_anim_scheduler #(
    .MAX_COUNT (24'd4),
    .NUM_ANIM  (6)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .step         (step),
    .lock         (lock),
    .div          (div),
    .anim_sel     (anim_sel),
    .frame_idx    (frame_idx),
    .frame_strobe (frame_strobe),
    .busy         (busy),
    .seq_done     (seq_done),
    .prescale_lo  (prescale_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // One clock edge. Outputs are sampled and inputs changed 1 ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance until frame_strobe is seen or the bound expires.
  task automatic wait_strobe(input int max_cyc, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!frame_strobe && n < max_cyc);
    check("strobe_seen", {31'd0, frame_strobe}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  int last_tab [6] = '{9, 6, 6, 6, 5, 5};
  int e_anim;
  int e_frame;
  int n;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    step  = 1'b0; lock  = 1'b0; div  = 8'd0;
    cyc();
    cyc();
    check("rst_anim",   {29'd0, anim_sel},      32'd0);
    check("rst_frame",  {28'd0, frame_idx},     32'd0);
    check("rst_strobe", {31'd0, frame_strobe},  32'd0);
    check("rst_busy",   {31'd0, busy},          32'd0);
    check("rst_done",   {31'd0, seq_done},      32'd0);
    check("rst_pre",    {24'd0, prescale_lo},   32'd0);
    reset = 1'b0;
    cyc();

    // First strobe arrives 5 cycles after start, with frame_idx = 1.
    pulse_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_pre",  {24'd0, prescale_lo}, 32'd0);
    repeat (4) cyc();
    check("pre_before_tick", {24'd0, prescale_lo}, 32'd4);
    check("no_strobe_c4",    {31'd0, frame_strobe}, 32'd0);
    cyc();
    check("strobe_c5",   {31'd0, frame_strobe}, 32'd1);
    check("frame1",      {28'd0, frame_idx},    32'd1);
    check("pre_cleared", {24'd0, prescale_lo},  32'd0);
    repeat (4) cyc();
    check("no_strobe_c9", {31'd0, frame_strobe}, 32'd0);
    cyc();
    check("strobe_c10", {31'd0, frame_strobe}, 32'd1);
    check("frame2",     {28'd0, frame_idx},    32'd2);

    // Remaining frames of the 43-frame sequence, checked against the table.
    e_anim  = 0;
    e_frame = 2;
    for (int k = 3; k <= 43; k++) begin
      if (e_frame < last_tab[e_anim]) begin
        e_frame++;
      end else begin
        e_frame = 0;
        e_anim  = (e_anim == 5) ? 0 : e_anim + 1;
      end
      wait_strobe(20, n);
      check("seq_period", n, 5);
      check("seq_anim",   {29'd0, anim_sel},  e_anim);
      check("seq_frame",  {28'd0, frame_idx}, e_frame);
      check("seq_done_pulse", {31'd0, seq_done}, (k == 43) ? 1 : 0);
    end
`ifdef SEG_ANIM_LOOP_EN
    check("loop_busy", {31'd0, busy}, 32'd1);
    check("loop_anim", {29'd0, anim_sel}, 32'd0);
    cyc();
    check("loop_done_clr", {31'd0, seq_done}, 32'd0);
    check("loop_busy2",    {31'd0, busy},     32'd1);
    pulse_stop();
`else
    check("end_busy", {31'd0, busy}, 32'd0);
    cyc();
    check("end_done_clr", {31'd0, seq_done},     32'd0);
    check("end_idle",     {31'd0, busy},         32'd0);
    check("end_strobe",   {31'd0, frame_strobe}, 32'd0);
    check("end_anim",     {29'd0, anim_sel},     32'd0);
`endif
    cyc();

    // div = 1 gives a 1025-cycle period. A div change 4 -> 1 at count 2000
    // ticks on the next edge.
    div = 8'h01;
    pulse_start();
    repeat (1024) cyc();
    check("div1_no_strobe", {31'd0, frame_strobe}, 32'd0);
    cyc();
    check("div1_strobe", {31'd0, frame_strobe}, 32'd1);
    check("div1_frame",  {28'd0, frame_idx},    32'd1);
    div = 8'h04;
    repeat (2000) cyc();
    check("div4_pre2000",   {24'd0, prescale_lo}, 32'd208);
    check("div4_no_strobe", {31'd0, frame_strobe}, 32'd0);
    div = 8'h01;
    cyc();
    check("divchg_strobe", {31'd0, frame_strobe}, 32'd1);
    check("divchg_frame",  {28'd0, frame_idx},    32'd2);
    check("divchg_pre",    {24'd0, prescale_lo},  32'd0);
    pulse_stop();
    check("stop_busy",  {31'd0, busy},      32'd0);
    check("stop_frame", {28'd0, frame_idx}, 32'd0);

    // Pause in the middle of anim 2, then apply three steps.
    div = 8'd0;
    pulse_start();
    for (int k = 1; k <= 20; k++) wait_strobe(20, n);
    check("p_anim",  {29'd0, anim_sel},  32'd2);
    check("p_frame", {28'd0, frame_idx}, 32'd3);
    cyc();
    cyc();
    pause = 1'b1;
    cyc();
    check("p_pre_enter", {24'd0, prescale_lo}, 32'd3);
    check("p_busy",      {31'd0, busy},        32'd1);
    cyc();
    check("p_pre_frozen", {24'd0, prescale_lo}, 32'd3);
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
      check("step_strobe", {31'd0, frame_strobe}, 32'd1);
      cyc();
      check("step_gap", {31'd0, frame_strobe}, 32'd0);
    end
    check("step_frame", {28'd0, frame_idx},   32'd6);
    check("step_anim",  {29'd0, anim_sel},    32'd2);
    check("step_pre",   {24'd0, prescale_lo}, 32'd3);
    pause = 1'b0;
    cyc();
    check("resume_pre0", {24'd0, prescale_lo},  32'd3);
    check("resume_nos0", {31'd0, frame_strobe}, 32'd0);
    cyc();
    check("resume_pre1", {24'd0, prescale_lo},  32'd4);
    cyc();
    check("resume_strobe", {31'd0, frame_strobe}, 32'd1);
    check("resume_anim",   {29'd0, anim_sel},     32'd3);
    check("resume_frame",  {28'd0, frame_idx},    32'd0);
    pulse_stop();

    // Lock held during anim 1.
    pulse_start();
    for (int k = 1; k <= 10; k++) wait_strobe(20, n);
    check("lk_anim_start", {29'd0, anim_sel}, 32'd1);
    lock = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      wait_strobe(20, n);
      check("lk_frame", {28'd0, frame_idx}, k % 7);
      check("lk_anim",  {29'd0, anim_sel},  32'd1);
    end
    lock = 1'b0;
    for (int k = 1; k <= 7; k++) wait_strobe(20, n);
    check("unlk_anim",  {29'd0, anim_sel},  32'd2);
    check("unlk_frame", {28'd0, frame_idx}, 32'd0);

    // stop and start together during RUN.
    stop  = 1'b1;
    start = 1'b1;
    cyc();
    stop  = 1'b0;
    start = 1'b0;
    check("ss_busy",  {31'd0, busy},      32'd0);
    check("ss_anim",  {29'd0, anim_sel},  32'd0);
    check("ss_frame", {28'd0, frame_idx}, 32'd0);
    cyc();
    check("ss_still_idle", {31'd0, busy}, 32'd0);

    // Reset in anim 4 overrides simultaneous start and pause.
    pulse_start();
    for (int k = 1; k <= 32; k++) wait_strobe(20, n);
    check("r4_anim",  {29'd0, anim_sel},  32'd4);
    check("r4_frame", {28'd0, frame_idx}, 32'd1);
    cyc();
    cyc();
    reset = 1'b1;
    start = 1'b1;
    pause = 1'b1;
    cyc();
    check("r4_rst_anim",   {29'd0, anim_sel},     32'd0);
    check("r4_rst_frame",  {28'd0, frame_idx},    32'd0);
    check("r4_rst_strobe", {31'd0, frame_strobe}, 32'd0);
    check("r4_rst_busy",   {31'd0, busy},         32'd0);
    check("r4_rst_done",   {31'd0, seq_done},     32'd0);
    check("r4_rst_pre",    {24'd0, prescale_lo},  32'd0);
    reset = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    cyc();
    check("r4_after_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
